// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI master transaction controller.
package spi_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // CLK cycles per SCLK half-period; zero flags an unusable frequency pair.
    function automatic int unsigned calc_half(input int unsigned in_hz,
                                              input int unsigned spi_hz);
        if (spi_hz == 0) begin
            return 0;
        end
        return in_hz / spi_hz / 2;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Restartable half-period timer: TICK is high for one cycle every HALF cycles.
module spi_half_tick #(
    parameter int unsigned HALF = 10
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic RESTART,
    output logic TICK
);

    localparam int unsigned CW = $clog2(HALF) + 1;

    logic [CW-1:0] cnt;

    // Count up, wrapping to zero on terminal count; RESTART realigns phase to now.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (RESTART || (cnt == CW'(HALF - 1))) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Terminal count marks the edge on which the controller acts.
    assign TICK = (cnt == CW'(HALF - 1));

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0, MSB-first SPI master: one chip-select-framed transfer per accepted START.
module spi_master_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned INPUT_CLK_FREQUENCY = 50000000,
    parameter int unsigned SPI_CLK_FREQUENCY   = 2500000,
    parameter int unsigned DATA_WIDTH          = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  MISO,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  CS_N,
    output logic                  SCLK,
    output logic                  MOSI
);

    localparam int unsigned HALF = calc_half(INPUT_CLK_FREQUENCY, SPI_CLK_FREQUENCY);
    localparam int unsigned BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    generate
        if (HALF < 1) begin : g_bad_half
            $error("spi_master_ctrl: SPI clock too fast for input clock (HALF < 1)");
        end
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("spi_master_ctrl: DATA_WIDTH must be at least 1");
        end
    endgenerate

    state_t                state;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [BW-1:0]         bit_cnt;
    logic                  tick;
    logic                  accept;
    logic [DATA_WIDTH:0]   rx_ext;
    logic [DATA_WIDTH-1:0] tx_next;

    // A new word is taken in IDLE, or on the very edge GAP ends (back-to-back).
    assign accept  = START && ((state == IDLE) || ((state == GAP) && tick));
    // Width-safe shifts that also elaborate for DATA_WIDTH == 1.
    assign rx_ext  = {rx_sh, MISO};
    assign tx_next = tx_sh << 1;

    spi_half_tick #(
        .HALF (HALF)
    ) u_half_tick (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .RESTART (accept),
        .TICK    (tick)
    );

    // Transfer sequencer with all pins and status registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RX_DATA <= '0;
            CS_N    <= 1'b1;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (accept) begin
                tx_sh   <= TX_DATA;
                rx_sh   <= '0;
                bit_cnt <= '0;
                CS_N    <= 1'b0;
                SCLK    <= 1'b0;
                MOSI    <= TX_DATA[DATA_WIDTH-1];
                BUSY    <= 1'b1;
                state   <= SHIFT;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    SHIFT: begin
                        if (tick) begin
                            if (!SCLK) begin
                                SCLK  <= 1'b1;
                                rx_sh <= rx_ext[DATA_WIDTH-1:0];
                            end else begin
                                SCLK <= 1'b0;
                                if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                                    // Last bit: MOSI holds through HOLD.
                                    state <= HOLD;
                                end else begin
                                    tx_sh   <= tx_next;
                                    MOSI    <= tx_next[DATA_WIDTH-1];
                                    bit_cnt <= bit_cnt + BW'(1);
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            CS_N    <= 1'b1;
                            RX_DATA <= rx_sh;
                            DONE    <= 1'b1;
                            MOSI    <= 1'b0;
                            state   <= GAP;
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with an expected-RX scoreboard.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] tx8 = 8'h00;
    logic       miso8;
    logic       busy8, done8, cs_n8, sclk8, mosi8;
    logic [7:0] rx8;

    logic        start16 = 1'b0;
    logic [15:0] tx16 = 16'h0000;
    logic        miso16;
    logic        busy16, done16, cs_n16, sclk16, mosi16;
    logic [15:0] rx16;

    logic       slave_mode = 1'b0;
    logic [7:0] slave_word = 8'h00;
    int         sl_idx = 7;
    logic       slv_bit;

    logic [15:0] exp_q[$];
    int passes = 0;
    int total = 0;

    int first_rise, last_fall, rise_cnt, done_k, done_cnt, busy_fall, cs_rise, cs_fall2;
    int mosi_zero;

    always #5 clk = ~clk;

    spi_master_ctrl dut8 (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start8),
        .TX_DATA (tx8),
        .MISO    (miso8),
        .BUSY    (busy8),
        .DONE    (done8),
        .RX_DATA (rx8),
        .CS_N    (cs_n8),
        .SCLK    (sclk8),
        .MOSI    (mosi8)
    );

    spi_master_ctrl #(
        .INPUT_CLK_FREQUENCY (50000000),
        .SPI_CLK_FREQUENCY   (25000000),
        .DATA_WIDTH          (16)
    ) dut16 (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start16),
        .TX_DATA (tx16),
        .MISO    (miso16),
        .BUSY    (busy16),
        .DONE    (done16),
        .RX_DATA (rx16),
        .CS_N    (cs_n16),
        .SCLK    (sclk16),
        .MOSI    (mosi16)
    );

    // Mode-0 slave: presents MSB when selected, advances on each SCLK fall.
    always @(negedge cs_n8) sl_idx = 7;
    always @(negedge sclk8) if (!cs_n8) sl_idx = sl_idx - 1;
    assign slv_bit = (sl_idx >= 0 && sl_idx <= 7) ? slave_word[sl_idx] : 1'b0;
    assign miso8   = slave_mode ? slv_bit : mosi8;
    assign miso16  = mosi16;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic sb_pop(input string tag, input logic [15:0] obs);
        check({tag, "_avail"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check(tag, {16'h0, obs}, {16'h0, exp_q.pop_front()});
    endtask

    // One 8-bit transfer on dut8 with stray STARTs at t0+50 / t0+179, optional
    // back-to-back START at t0+180, and optional reset at t0+rst_at.
    task automatic xfer8(input logic [7:0] tx, input logic [7:0] exp_rx, input bit b2b,
                         input int rst_at);
        logic p_sclk, p_cs, p_busy;
        int   limit;
        limit = b2b ? 370 : 200;
        first_rise = -1; last_fall = -1; rise_cnt = 0; done_k = -1; done_cnt = 0;
        busy_fall = -1; cs_rise = -1; cs_fall2 = -1; mosi_zero = 0;
        tx8 = tx;
        start8 = 1'b1;
        exp_q.push_back({8'h00, exp_rx});
        tick;
        start8 = 1'b0;
        check("t0_cs_n", cs_n8, 0);
        check("t0_busy", busy8, 1);
        check("t0_mosi", mosi8, tx[7]);
        p_sclk = sclk8; p_cs = cs_n8; p_busy = busy8;
        for (int k = 1; k <= limit; k++) begin
            start8 = (k == 50 || k == 179 || (b2b && k == 180));
            if (k == 1) tx8 = ~tx;
            if (b2b && k == 180) begin
                tx8 = 8'h5A;
                exp_q.push_back(16'h005A);
            end
            tick;
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_cs_n", cs_n8, 1);
                check("rst_sclk", sclk8, 0);
                check("rst_mosi", mosi8, 0);
                check("rst_busy", busy8, 0);
                exp_q.delete();
                start8 = 1'b0;
                repeat (3) begin
                    tick;
                    if (done8) done_cnt++;
                end
                rst_n = 1'b1;
                break;
            end
            if (!p_sclk && sclk8) begin
                if (first_rise < 0) first_rise = k;
                if (k <= 170 && !cs_n8) rise_cnt++;
            end
            if (p_sclk && !sclk8 && k <= 170) last_fall = k;
            if (done8) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                sb_pop("rx_data", {8'h00, rx8});
            end
            if (!p_cs && cs_n8 && cs_rise < 0) cs_rise = k;
            if (p_cs && !cs_n8 && cs_fall2 < 0) cs_fall2 = k;
            if (p_busy && !busy8 && busy_fall < 0) busy_fall = k;
            if (k < 170 && !cs_n8 && !mosi8) mosi_zero++;
            p_sclk = sclk8; p_cs = cs_n8; p_busy = busy8;
        end
        start8 = 1'b0;
    endtask

    initial begin
        int bad;
        int d16;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_cs_n", cs_n8, 1);
        check("reset_sclk", sclk8, 0);
        check("reset_mosi", mosi8, 0);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_rx", {24'h0, rx8}, 0);
        check("reset_cs_n16", cs_n16, 1);
        rst_n = 1'b1;
        tick;
        tick;

        // Loopback 0xA5: frame timing and stray STARTs ignored
        xfer8(8'hA5, 8'hA5, 1'b0, -1);
        check("a5_first_rise", first_rise, 10);
        check("a5_last_fall", last_fall, 160);
        check("a5_rise_cnt", rise_cnt, 8);
        check("a5_done_k", done_k, 170);
        check("a5_done_cnt", done_cnt, 1);
        check("a5_cs_rise", cs_rise, 170);
        check("a5_busy_fall", busy_fall, 180);
        check("a5_cs_refall", cs_fall2, -1);
        tick;

        // Slave returns 0x3C while sending 0xFF
        slave_mode = 1'b1;
        slave_word = 8'h3C;
        xfer8(8'hFF, 8'h3C, 1'b0, -1);
        check("ff_mosi_zero", mosi_zero, 0);
        check("ff_rise_cnt", rise_cnt, 8);
        check("ff_done_k", done_k, 170);
        slave_mode = 1'b0;
        tick;

        // Back-to-back: START on the edge BUSY would fall is accepted
        xfer8(8'hC3, 8'hC3, 1'b1, -1);
        check("b2b_done_k", done_k, 170);
        check("b2b_cs_refall", cs_fall2, 180);
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_busy_fall", busy_fall, 360);
        tick;

        // Reset mid-transfer discards the word; next transfer is normal
        xfer8(8'h71, 8'h71, 1'b0, 75);
        check("rst_no_done", done_cnt, 0);
        tick;
        xfer8(8'h96, 8'h96, 1'b0, -1);
        check("post_rst_done_k", done_k, 170);
        check("post_rst_busy_fall", busy_fall, 180);
        tick;

        // HALF=1, 16-bit loopback
        tx16 = 16'h8001;
        start16 = 1'b1;
        exp_q.push_back(16'h8001);
        tick;
        start16 = 1'b0;
        check("h1_t0_cs_n", cs_n16, 0);
        check("h1_t0_mosi", mosi16, 1);
        bad = 0;
        d16 = -1;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (k <= 32 && sclk16 !== k[0]) bad++;
            if (done16) begin
                if (d16 < 0) d16 = k;
                sb_pop("h1_rx_data", rx16);
            end
        end
        check("h1_sclk_toggle", bad, 0);
        check("h1_done_k", d16, 33);
        check("h1_busy_end", busy16, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
